// File: rtl/cluster_clock_divider.sv
// Programmable integer clock divider with glitch-free ratio changes at period boundaries.
// Optional macro CLUSTER_CLK_DIV_TESTMODE_EN lets test_mode_i force clk_o to follow clk_i.
module cluster_clock_divider #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             test_mode_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_valid_i,
  output logic             div_ack_o,
  output logic             busy_o,
  output logic             clk_o
);

  logic [DIV_W-1:0] cur_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] pend_div_q;
  logic             div_q;
  logic             pend_q;
  logic             ack_q;

  logic             bypass;
  logic             period_end;
  logic             capture;
  logic             apply;
  logic [DIV_W-1:0] half;

  always_comb begin
    bypass     = (cur_q <= DIV_W'(1));
    half       = cur_q >> 1;
    period_end = bypass || (cnt_q == cur_q - DIV_W'(1));
    capture    = div_valid_i && !pend_q && !ack_q;
    // A new ratio only lands on a period end, so the running period is never cut short.
    apply      = pend_q && period_end;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cur_q  <= DIV_W'(DEFAULT_DIV);
      cnt_q  <= '0;
      div_q  <= 1'b0;
      pend_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      div_q <= !bypass && (cnt_q < half);
      ack_q <= apply;
      if (apply) begin
        cur_q  <= pend_div_q;
        cnt_q  <= '0;
        pend_q <= 1'b0;
      end else begin
        if (capture) pend_q <= 1'b1;
        cnt_q <= period_end ? '0 : cnt_q + DIV_W'(1);
      end
    end
  end

  // Captured ratio is held until applied; later changes on div_i are ignored.
  always_ff @(posedge clk_i) begin
    if (capture) pend_div_q <= div_i;
  end

  assign busy_o    = pend_q;
  assign div_ack_o = ack_q;

`ifdef CLUSTER_CLK_DIV_TESTMODE_EN
  assign clk_o = (test_mode_i || bypass) ? clk_i : div_q;
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode_i;
  assign clk_o = bypass ? clk_i : div_q;
`endif

endmodule

// File: tb/tb_cluster_clock_divider.sv
// Directed bench for cluster_clock_divider (DEFAULT_DIV=4): reset pattern, ratio changes,
// bypass entry/exit, held-valid re-request, reset mid-request and test mode.
module tb_cluster_clock_divider;

  logic       clk;
  logic       rstn;
  logic       test_mode;
  logic [7:0] div;
  logic       div_valid;
  logic       div_ack;
  logic       busy;
  logic       clk_out;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  cluster_clock_divider #(.DIV_W(8), .DEFAULT_DIV(4)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .test_mode_i (test_mode),
    .div_i       (div),
    .div_valid_i (div_valid),
    .div_ack_o   (div_ack),
    .busy_o      (busy),
    .clk_o       (clk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_negedge();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic run_pattern(input string tag, input int n, input int period, input int start);
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, clk_out, ((start + i) % period) < (period / 2));
      chk({tag, "_ack"}, div_ack, 1'b0);
    end
  endtask

  initial begin
    rstn      = 1'b0;
    test_mode = 1'b0;
    div       = 8'd0;
    div_valid = 1'b0;

    step();
    step();
    chk("rst_clk", clk_out, 1'b0);
    chk("rst_ack", div_ack, 1'b0);
    chk("rst_busy", busy, 1'b0);

    rstn = 1'b1;
    run_pattern("div4", 8, 4, 0);
    chk("div4_busy", busy, 1'b0);

    // div 4 -> 3, requested with cnt_q = 1
    step();
    chk("pre3_clk", clk_out, 1'b1);
    div_valid = 1'b1;
    div       = 8'd3;
    step();
    chk("req3_busy", busy, 1'b1);
    chk("req3_ack", div_ack, 1'b0);
    chk("req3_clk", clk_out, 1'b1);
    div = 8'd7;
    step();
    chk("req3_busy2", busy, 1'b1);
    chk("req3_clk2", clk_out, 1'b0);
    step();
    chk("app3_ack", div_ack, 1'b1);
    chk("app3_busy", busy, 1'b0);
    chk("app3_clk", clk_out, 1'b0);
    div_valid = 1'b0;
    run_pattern("div3", 6, 3, 0);

    // div 3 -> 1 (bypass entry)
    div_valid = 1'b1;
    div       = 8'd1;
    step();
    chk("req1_busy", busy, 1'b1);
    step();
    chk("req1_ack_early", div_ack, 1'b0);
    step();
    chk("app1_ack", div_ack, 1'b1);
    chk("byp_clk_hi", clk_out, 1'b1);
    div_valid = 1'b0;
    at_negedge();
    chk("byp_clk_lo", clk_out, 1'b0);
    step();
    chk("byp_ack_clr", div_ack, 1'b0);
    chk("byp_clk_hi2", clk_out, 1'b1);

    // bypass -> 5: ack two cycles after valid
    div_valid = 1'b1;
    div       = 8'd5;
    step();
    chk("req5_busy", busy, 1'b1);
    chk("req5_ack", div_ack, 1'b0);
    chk("req5_clk", clk_out, 1'b1);
    step();
    chk("app5_ack", div_ack, 1'b1);
    chk("app5_busy", busy, 1'b0);
    chk("app5_clk", clk_out, 1'b0);
    div_valid = 1'b0;
    run_pattern("div5", 10, 5, 0);

    // div 5 -> 6 with valid held one cycle past ack: second request of 6
    div_valid = 1'b1;
    div       = 8'd6;
    step();
    chk("req6_busy", busy, 1'b1);
    step();
    step();
    step();
    chk("req6_ack_early", div_ack, 1'b0);
    step();
    chk("app6_ack", div_ack, 1'b1);
    step();
    chk("hold_ack_clr", div_ack, 1'b0);
    chk("hold_busy_clr", busy, 1'b0);
    chk("hold_clk0", clk_out, 1'b1);
    step();
    chk("recap_busy", busy, 1'b1);
    chk("hold_clk1", clk_out, 1'b1);
    div_valid = 1'b0;
    run_pattern("div6_hold", 3, 6, 2);
    chk("recap_busy2", busy, 1'b1);
    step();
    chk("reapp_ack", div_ack, 1'b1);
    chk("reapp_busy", busy, 1'b0);
    chk("reapp_clk", clk_out, 1'b0);
    run_pattern("div6", 12, 6, 0);

    // div 6 -> 2
    div_valid = 1'b1;
    div       = 8'd2;
    for (int i = 0; i < 5; i++) step();
    chk("req2_busy", busy, 1'b1);
    chk("req2_ack_early", div_ack, 1'b0);
    step();
    chk("app2_ack", div_ack, 1'b1);
    div_valid = 1'b0;
    run_pattern("div2", 4, 2, 0);

    // div 2 -> 0: switch only at period end, high phase not shortened
    div_valid = 1'b1;
    div       = 8'd0;
    step();
    chk("req0_busy", busy, 1'b1);
    chk("req0_clk", clk_out, 1'b1);
    at_negedge();
    chk("req0_clk_neg", clk_out, 1'b1);
    step();
    chk("app0_ack", div_ack, 1'b1);
    chk("app0_clk", clk_out, 1'b1);
    div_valid = 1'b0;
    at_negedge();
    chk("app0_clk_neg", clk_out, 1'b0);
    step();
    chk("byp0_ack_clr", div_ack, 1'b0);
    chk("byp0_clk", clk_out, 1'b1);
    at_negedge();
    chk("byp0_clk_neg", clk_out, 1'b0);

    // reset while a request is pending
    div_valid = 1'b1;
    div       = 8'd7;
    step();
    chk("req7_busy", busy, 1'b1);
    rstn      = 1'b0;
    div_valid = 1'b0;
    step();
    chk("midrst_ack", div_ack, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_clk", clk_out, 1'b0);
    rstn = 1'b1;
    run_pattern("div4_again", 8, 4, 0);
    chk("div4_again_busy", busy, 1'b0);

    // test mode at div 4
    test_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
`ifdef CLUSTER_CLK_DIV_TESTMODE_EN
      chk("tm_clk_hi", clk_out, 1'b1);
      at_negedge();
      chk("tm_clk_lo", clk_out, 1'b0);
`else
      chk("tm_clk_hi", clk_out, ((8 + i) % 4) < 2);
      at_negedge();
      chk("tm_clk_lo", clk_out, ((8 + i) % 4) < 2);
`endif
    end
    test_mode = 1'b0;
    run_pattern("tm_off", 4, 4, 12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
